// File: rtl/fir_mac_scheduler_if.sv
// Bus bundle for fir_mac_scheduler: sample capture, ring-buffer write port,
// FIR engine control and tagged result. master = system side, slave = scheduler.
interface fir_mac_scheduler_if #(
  parameter int unsigned NUM_CH = 2
);
  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       sample_valid_in;
  logic [NUM_CH-1:0][15:0] sample_in;
  logic                    overrun_clr_in;

  logic                    buf_we_out;
  logic [ChW-1:0]          buf_ch_out;
  logic [5:0]              buf_addr_out;
  logic signed [15:0]      buf_data_out;

  logic                    fir_start_out;
  logic [ChW-1:0]          fir_ch_out;
  logic [5:0]              fir_offset_out;
  logic signed [15:0]      fir_result_in;

  logic                    result_valid_out;
  logic [ChW-1:0]          result_ch_out;
  logic signed [15:0]      result_out;
  logic [NUM_CH-1:0]       overrun_out;

  modport master (
    output sample_valid_in, sample_in, overrun_clr_in, fir_result_in,
    input  buf_we_out, buf_ch_out, buf_addr_out, buf_data_out,
    input  fir_start_out, fir_ch_out, fir_offset_out,
    input  result_valid_out, result_ch_out, result_out, overrun_out
  );

  modport slave (
    input  sample_valid_in, sample_in, overrun_clr_in, fir_result_in,
    output buf_we_out, buf_ch_out, buf_addr_out, buf_data_out,
    output fir_start_out, fir_ch_out, fir_offset_out,
    output result_valid_out, result_ch_out, result_out, overrun_out
  );
endinterface

// File: rtl/fir_mac_scheduler.sv
// Time-shares one FIR MAC engine between NUM_CH channels: captures samples into
// per-channel ring buffers and round-robins engine runs, latching tagged results.
module fir_mac_scheduler #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned RUN_CYCLES = 66
) (
  input  logic               clk_in,
  input  logic               rst_in,
  fir_mac_scheduler_if.slave bus
);
  localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CntW = $clog2(RUN_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StLatch} state_e;

  state_e                  state_q, state_d;
  logic [ChW-1:0]          sel_q, sel_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [ChW-1:0]          rr_q, rr_d;
  logic [NUM_CH-1:0][15:0] hold_q, hold_d;
  logic [NUM_CH-1:0]       hold_v_q, hold_v_d;
  logic [NUM_CH-1:0]       pending_q, pending_d;
  logic [NUM_CH-1:0]       overrun_q, overrun_d;
  logic [NUM_CH-1:0][5:0]  wr_ptr_q, wr_ptr_d;
  logic [NUM_CH-1:0][5:0]  last_addr_q, last_addr_d;

  logic                    buf_we_q, buf_we_d;
  logic [ChW-1:0]          buf_ch_q, buf_ch_d;
  logic [5:0]              buf_addr_q, buf_addr_d;
  logic signed [15:0]      buf_data_q, buf_data_d;
  logic                    fir_start_q, fir_start_d;
  logic [ChW-1:0]          fir_ch_q, fir_ch_d;
  logic [5:0]              fir_off_q, fir_off_d;
  logic                    res_v_q, res_v_d;
  logic [ChW-1:0]          res_ch_q, res_ch_d;
  logic signed [15:0]      res_q, res_d;

  logic                    go;
  logic [ChW-1:0]          pick, cand;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       ovr_set;
  logic                    wrote;

  // First pending channel at or after rr_q, cyclically; only meaningful in StIdle.
  always_comb begin
    go   = 1'b0;
    pick = rr_q;
    cand = rr_q;
    if (state_q == StIdle) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        cand = ChW'((32'(rr_q) + k) % NUM_CH);
        if (!go && pending_q[cand]) begin
          go   = 1'b1;
          pick = cand;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    hold_d      = hold_q;
    hold_v_d    = hold_v_q;
    pending_d   = pending_q;
    wr_ptr_d    = wr_ptr_q;
    last_addr_d = last_addr_q;
    buf_we_d    = 1'b0;
    buf_ch_d    = buf_ch_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    fir_start_d = 1'b0;
    fir_ch_d    = fir_ch_q;
    fir_off_d   = fir_off_q;
    res_v_d     = 1'b0;
    res_ch_d    = res_ch_q;
    res_d       = res_q;
    ovr_set     = '0;
    busy        = '0;
    wrote       = 1'b0;

    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.sample_valid_in[c]) begin
        hold_d[c]   = bus.sample_in[c];
        hold_v_d[c] = 1'b1;
        if (hold_v_q[c]) ovr_set[c] = 1'b1;
      end
    end

    // A write becomes pending once the buffer has committed it (one cycle after issue).
    if (buf_we_q) pending_d[buf_ch_q] = 1'b1;

    // The channel being selected this cycle is already treated as busy.
    for (int c = 0; c < NUM_CH; c++) begin
      busy[c] = ((state_q != StIdle) && (sel_q == ChW'(c))) || (go && (pick == ChW'(c)));
      if (!wrote && hold_v_d[c] && !busy[c]) begin
        wrote          = 1'b1;
        buf_we_d       = 1'b1;
        buf_ch_d       = ChW'(c);
        buf_addr_d     = wr_ptr_q[c];
        buf_data_d     = hold_d[c];
        last_addr_d[c] = wr_ptr_q[c];
        wr_ptr_d[c]    = wr_ptr_q[c] + 6'd1;
        hold_v_d[c]    = 1'b0;
        if (pending_q[c] || (buf_we_q && (buf_ch_q == ChW'(c)))) ovr_set[c] = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d     = StStart;
          sel_d       = pick;
          fir_start_d = 1'b1;
          fir_ch_d    = pick;
          fir_off_d   = last_addr_q[pick];
          cnt_d       = '0;
        end
      end
      StStart: begin
        state_d = StRun;
        cnt_d   = '0;
      end
      StRun: begin
        if (cnt_q == CntW'(RUN_CYCLES - 1)) state_d = StLatch;
        else                                cnt_d   = cnt_q + 1'b1;
      end
      StLatch: begin
        res_v_d  = 1'b1;
        res_ch_d = sel_q;
        res_d    = bus.fir_result_in;
        rr_d     = (32'(sel_q) == NUM_CH - 1) ? '0 : sel_q + 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // The run just selected already covers any write committed this cycle.
    if (go) pending_d[pick] = 1'b0;

    overrun_d = (bus.overrun_clr_in ? '0 : overrun_q) | ovr_set;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      cnt_q       <= '0;
      rr_q        <= '0;
      hold_q      <= '0;
      hold_v_q    <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      wr_ptr_q    <= '0;
      last_addr_q <= {NUM_CH{6'h3f}};
      buf_we_q    <= 1'b0;
      buf_ch_q    <= '0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      fir_start_q <= 1'b0;
      fir_ch_q    <= '0;
      fir_off_q   <= '0;
      res_v_q     <= 1'b0;
      res_ch_q    <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      last_addr_q <= last_addr_d;
      buf_we_q    <= buf_we_d;
      buf_ch_q    <= buf_ch_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      fir_start_q <= fir_start_d;
      fir_ch_q    <= fir_ch_d;
      fir_off_q   <= fir_off_d;
      res_v_q     <= res_v_d;
      res_ch_q    <= res_ch_d;
      res_q       <= res_d;
    end
  end

  assign bus.buf_we_out       = buf_we_q;
  assign bus.buf_ch_out       = buf_ch_q;
  assign bus.buf_addr_out     = buf_addr_q;
  assign bus.buf_data_out     = buf_data_q;
  assign bus.fir_start_out    = fir_start_q;
  assign bus.fir_ch_out       = fir_ch_q;
  assign bus.fir_offset_out   = fir_off_q;
  assign bus.result_valid_out = res_v_q;
  assign bus.result_ch_out    = res_ch_q;
  assign bus.result_out       = res_q;
  assign bus.overrun_out      = overrun_q;
endmodule

// File: doc/fir_mac_scheduler.md
# fir_mac_scheduler

Sequencer that time-shares one 63-tap FIR MAC engine between NUM_CH audio channels (e.g. feedforward and feedback mics of the ANC path). It captures per-channel input samples and writes them into a per-channel 64-entry ring buffer. It tracks each channel's newest-sample offset and round-robins filter runs, issuing the engine's one-cycle start strobe with channel and offset. A fixed number of cycles later it latches the engine's 16-bit output as a tagged result.

## Interface
- NUM_CH, 2, number of channels sharing the engine (1..4)
- RUN_CYCLES, 66, cycles spent in RUN before latching the engine output (engine needs ≥65)
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-low reset
- sample_valid_in  input  NUM_CH  one-cycle strobe per channel, new sample present
- sample_in  input  NUM_CH×16 signed  per-channel sample, sampled when its strobe is high
- overrun_clr_in  input  1  clears all overrun_out bits
- buf_we_out  output  1  ring-buffer write enable
- buf_ch_out  output  clog2(NUM_CH)  channel being written
- buf_addr_out  output  6  ring-buffer address
- buf_data_out  output  16 signed  sample written
- fir_start_out  output  1  one-cycle start strobe to engine (its ready_in)
- fir_ch_out  output  clog2(NUM_CH)  channel/weight-set select, held from START until next START
- fir_offset_out  output  6  address of newest sample of fir_ch_out, held likewise
- fir_result_in  input  16 signed  engine output (signal_out)
- result_valid_out  output  1  one-cycle strobe, result_out valid
- result_ch_out  output  clog2(NUM_CH)  channel of result_out
- result_out  output  16 signed  filtered sample
- overrun_out  output  NUM_CH  sticky per-channel overrun flags

## Operation
- Capture: a high sample_valid_in[c] loads hold[c] and sets hold_v[c]. If hold_v[c] is already set, hold[c] is overwritten and overrun[c] is set.
- Write: each cycle, the lowest-index channel with hold_v set and not currently busy is written. It drives buf_we_out=1 with buf_addr_out=wr_ptr[c]. last_addr[c] is set to wr_ptr[c], wr_ptr[c] increments mod 64 (63→0), hold_v[c] clears and pending[c] sets.
- A channel is busy while the FSM is in START/RUN/LATCH for it. Its writes are deferred until the FSM returns to IDLE, so the buffer is never modified mid-run.
- Write with pending[c] already set (run not yet started): sets overrun[c]. The later run uses the newest offset.
- FSM states IDLE, START, RUN, LATCH.
  - IDLE: if any pending, pick the first pending channel at or after rr_ptr (cyclic) and go to START. Otherwise stay.
  - START: fir_start_out=1; fir_ch_out and fir_offset_out are loaded from the channel and last_addr; pending clears; the cycle counter clears; go to RUN.
  - RUN: count RUN_CYCLES cycles, then go to LATCH.
  - LATCH: result_out<=fir_result_in, result_ch_out<=ch, result_valid_out<=1, rr_ptr<=ch+1 mod NUM_CH; go to IDLE.
- overrun_out is OR-accumulated.
  - overrun_clr_in clears it.
  - A set event in the same cycle as a clear wins (bit ends at 1).
- Reset (rst_in=0, any state incl. mid-RUN): state IDLE; all outputs 0; hold_v, pending, overrun, wr_ptr and rr_ptr 0; last_addr 63. No result is emitted for an aborted run.

## Timing
- Cycle 0 = sample_valid_in[c] high, idle, no contention.
  - Cycle 1: buf_we_out=1.
  - Cycle 2: IDLE selects.
  - Cycle 3: fir_start_out=1.
  - Cycles 4..3+RUN_CYCLES: RUN.
  - Cycle 4+RUN_CYCLES: LATCH.
  - Cycle 5+RUN_CYCLES (71 by default): result_valid_out=1.
- Back-to-back runs: START-to-START period is RUN_CYCLES+3 cycles (69).
- Sustained input rate per channel must be ≤1 per NUM_CH×(RUN_CYCLES+3) cycles; faster input produces overrun, not corruption.
- Simultaneous strobes on several channels: writes occur on consecutive cycles, lowest index first.
- Outputs buf_*, fir_*, result_* are registered. fir_start_out and result_valid_out are never high for 2 consecutive cycles.

## Test plan
- Reset then single sample 0x0100 on ch0: buf write addr 0 at cycle 1; fir_start_out at cycle 3 with ch0, offset 0; result_valid_out at cycle 71, result_ch_out=0, result_out=fir_result_in value at cycle 70.
- 65 ch0 samples spaced 200 cycles: addresses 0..63 then 0. The 65th run has offset 0; overrun_out stays 0.
- ch0 and ch1 strobed same cycle: writes ch0 cycle 1, ch1 cycle 2; starts ch0 cycle 3, ch1 cycle 72; results ch0 then ch1.
- ch1 strobe during ch1 RUN: write deferred until after LATCH (IDLE cycle). The next start for ch1 uses the new offset; no overrun.
- Three ch0 strobes 10 cycles apart while ch1 runs: overrun_out[0]=1, a single ch0 run with offset of the third sample; overrun_clr_in pulse clears it.
- rst_in low at RUN cycle 30: next cycle all outputs 0, no result_valid_out. Pre-reset pending work is dropped; a new sample after reset writes addr 0.
